rrd_skid_stage: RTL

Registered, branch-aware elastic buffer that sits directly downstream of the register-read decode stage and upstream of the execution unit issue port. It holds up to two in-flight micro-ops in FIFO order and applies branch resolution and misprediction updates to every held uop each cycle. It also drops uops on pipeline flush. The stage decouples execution-unit back-pressure from issue without losing throughput.

---
 rtl/rrd_skid_stage_pkg.sv | 18 +
 rtl/rrd_slot.sv | 41 ++++
 rtl/rrd_skid_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/rrd_skid_stage_pkg.sv
// Core-wide branch-tracking definitions shared by the branch-aware buffers.
package rrd_skid_stage_pkg;

  localparam int BR_W = 20;

  typedef struct packed {
    logic [BR_W-1:0] resolve_mask;
    logic [BR_W-1:0] mispredict_mask;
  } brupdate_t;

  // A uop dies when flushed or when any of its branches mispredicted.
  function automatic logic kill_by_mask(input logic [BR_W-1:0] mask,
                                        input logic [BR_W-1:0] mispredict,
                                        input logic            flush);
    return flush | (|(mask & mispredict));
  endfunction

endpackage

// File: rtl/rrd_slot.sv
// One storage slot of the skid stage: valid, branch mask and opaque payload.
module rrd_slot #(
  parameter int PAYLOAD_W = 160,
  parameter int BR_W      = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 clear,
  input  logic [BR_W-1:0]      load_mask,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic [BR_W-1:0]      resolve_mask,
  output logic                 valid,
  output logic [BR_W-1:0]      mask,
  output logic [PAYLOAD_W-1:0] payload
);

  // A held occupant keeps its valid bit and only sheds resolved branches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      mask  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      mask  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      mask  <= load_mask & ~resolve_mask;
    end else begin
      mask  <= mask & ~resolve_mask;
    end
  end

  // Payload is don't-care while invalid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (load && !clear) begin
      payload <= load_payload;
    end
  end

endmodule

// File: rtl/rrd_skid_stage.sv
// Two-entry branch-aware elastic buffer between register-read and execute issue.
module rrd_skid_stage #(
  parameter int PAYLOAD_W = 160,
  parameter int BR_W      = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BR_W-1:0]      in_br_mask,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [BR_W-1:0]      brupd_resolve_mask,
  input  logic [BR_W-1:0]      brupd_mispredict_mask,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BR_W-1:0]      out_br_mask,
  output logic [PAYLOAD_W-1:0] out_payload
);

  import rrd_skid_stage_pkg::*;

  brupdate_t brupd;

  logic                 head_valid, tail_valid;
  logic [BR_W-1:0]      head_mask, tail_mask;
  logic [PAYLOAD_W-1:0] head_payload, tail_payload;

  logic head_kill, tail_kill, in_kill;
  logic in_fire, out_fire;
  logic head_keep, tail_keep, in_keep;

  logic                 head_load, head_clear, tail_load, tail_clear;
  logic [BR_W-1:0]      head_src_mask;
  logic [PAYLOAD_W-1:0] head_src_payload;

  assign brupd = '{resolve_mask: brupd_resolve_mask, mispredict_mask: brupd_mispredict_mask};

  assign head_kill = kill_by_mask(head_mask, brupd.mispredict_mask, flush);
  assign tail_kill = kill_by_mask(tail_mask, brupd.mispredict_mask, flush);
  assign in_kill   = kill_by_mask(in_br_mask, brupd.mispredict_mask, flush);

  // Ready depends on registered state only, so a pop never frees space the same cycle.
  assign in_ready    = ~tail_valid;
  assign in_fire     = in_valid & in_ready;
  assign out_valid   = head_valid & ~head_kill;
  assign out_fire    = out_valid & out_ready;
  assign out_br_mask = head_mask & ~brupd.resolve_mask;
  assign out_payload = head_payload;

  assign head_keep = head_valid & ~head_kill & ~out_fire;
  assign tail_keep = tail_valid & ~tail_kill;
  assign in_keep   = in_fire & ~in_kill;

  // Pack survivors oldest-first; in_fire implies an empty tail, so at most two survive.
  always_comb begin
    head_load        = 1'b0;
    head_clear       = 1'b0;
    tail_load        = 1'b0;
    tail_clear       = 1'b0;
    head_src_mask    = in_br_mask;
    head_src_payload = in_payload;

    if (head_keep) begin
      head_load = 1'b0;
    end else if (tail_keep) begin
      head_load        = 1'b1;
      head_src_mask    = tail_mask;
      head_src_payload = tail_payload;
    end else if (in_keep) begin
      head_load = 1'b1;
    end else begin
      head_clear = 1'b1;
    end

    if (head_keep && tail_keep) begin
      tail_load = 1'b0;
    end else if ((head_keep || tail_keep) && in_keep) begin
      tail_load = 1'b1;
    end else begin
      tail_clear = 1'b1;
    end
  end

  rrd_slot #(.PAYLOAD_W(PAYLOAD_W), .BR_W(BR_W)) u_head (
    .clock        (clock),
    .reset        (reset),
    .load         (head_load),
    .clear        (head_clear),
    .load_mask    (head_src_mask),
    .load_payload (head_src_payload),
    .resolve_mask (brupd.resolve_mask),
    .valid        (head_valid),
    .mask         (head_mask),
    .payload      (head_payload)
  );

  rrd_slot #(.PAYLOAD_W(PAYLOAD_W), .BR_W(BR_W)) u_tail (
    .clock        (clock),
    .reset        (reset),
    .load         (tail_load),
    .clear        (tail_clear),
    .load_mask    (in_br_mask),
    .load_payload (in_payload),
    .resolve_mask (brupd.resolve_mask),
    .valid        (tail_valid),
    .mask         (tail_mask),
    .payload      (tail_payload)
  );

endmodule
